pc_unit: RTL

//   Parametrised program-counter unit for the RV32I fetch stage: holds the PC register,

---
 rtl/pc_unit_pkg.sv | 15 +
 rtl/pc_unit_if.sv | 16 +
 rtl/pc_unit_adder.sv | 10 +
 rtl/pc_unit.sv | 49 ++++
 4 files changed

// File: rtl/pc_unit_pkg.sv
// pc_unit_pkg: shared defaults and next-PC select encoding for the RV32I fetch PC unit.
package pc_unit_pkg;
   localparam int          DEF_XLEN         = 32;
   localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
   localparam logic [31:0] DEF_TRAP_VECTOR  = 32'h0000_0100;
   localparam int          DEF_INC          = 4;
   localparam int          DEF_ALIGN_BITS   = 2;
   typedef enum logic [1:0] {SEL_SEQ, SEL_HOLD, SEL_REDIR, SEL_TRAP} pc_sel_e;
   // trap > misaligned redirect > redirect > stall > sequential
   function automatic pc_sel_e pc_select(input logic trap, input logic redir,
                                         input logic misaligned, input logic stall);
      return trap ? SEL_TRAP : redir ? (misaligned ? SEL_TRAP : SEL_REDIR) :
             stall ? SEL_HOLD : SEL_SEQ;
   endfunction
endpackage

// File: rtl/pc_unit_if.sv
// pc_unit_if: control inputs and PC outputs of the fetch PC unit.
interface pc_unit_if #(parameter int XLEN = 32);
   logic            stall;
   logic            redirect;
   logic [XLEN-1:0] redirect_pc;
   logic            trap_req;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] pc_plus_inc;
   logic            pc_valid;
   logic            misalign_err;
   logic [XLEN-1:0] bad_addr;
   modport master (output stall, redirect, redirect_pc, trap_req,
                   input pc, pc_plus_inc, pc_valid, misalign_err, bad_addr);
   modport slave (input stall, redirect, redirect_pc, trap_req,
                  output pc, pc_plus_inc, pc_valid, misalign_err, bad_addr);
endinterface

// File: rtl/pc_unit_adder.sv
// pc_unit_adder: combinational sequential-increment adder, wraps modulo 2^XLEN.
module pc_unit_adder #(
   parameter int XLEN = 32,
   parameter int INC  = 4
) (
   input  logic [XLEN-1:0] i_pc,
   output logic [XLEN-1:0] o_sum
);
   assign o_sum = i_pc + XLEN'(INC);
endmodule

// File: rtl/pc_unit.sv
// pc_unit: RV32I fetch program counter with stall, redirect, trap and
// misaligned-target trapping.
module pc_unit
   import pc_unit_pkg::*;
#(
   parameter int              XLEN         = DEF_XLEN,
   parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEF_RESET_VECTOR),
   parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(DEF_TRAP_VECTOR),
   parameter int              INC          = DEF_INC,
   parameter int              ALIGN_BITS   = DEF_ALIGN_BITS
) (
   input logic        clk,
   input logic        rst,
   pc_unit_if.slave   bus
);
   localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((64'd1 << ALIGN_BITS) - 64'd1);
   logic [XLEN-1:0] r_pc, r_bad, w_pc_inc, w_next;
   logic            r_valid, r_err, w_mis, w_mis_take;
   pc_sel_e         w_sel;
   pc_unit_adder #(.XLEN(XLEN), .INC(INC)) u_adder (.i_pc(r_pc), .o_sum(w_pc_inc));
   assign w_mis      = |(bus.redirect_pc & ALIGN_MASK);
   assign w_sel      = pc_select(bus.trap_req, bus.redirect, w_mis, bus.stall);
   assign w_mis_take = bus.redirect & w_mis & ~bus.trap_req;
   always_comb begin
      w_next = w_sel == SEL_TRAP  ? TRAP_VECTOR :
               w_sel == SEL_REDIR ? bus.redirect_pc :
               w_sel == SEL_HOLD  ? r_pc : w_pc_inc;
   end
   // The first edge after reset release only raises pc_valid; controls are ignored.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc    <= RESET_VECTOR;
         r_valid <= 1'b0;
         r_err   <= 1'b0;
         r_bad   <= '0;
      end else if (!r_valid) begin
         r_valid <= 1'b1;
      end else begin
         r_pc  <= w_next;
         r_err <= w_mis_take;
         if (w_mis_take) r_bad <= bus.redirect_pc;
      end
   end
   assign bus.pc           = r_pc;
   assign bus.pc_plus_inc  = w_pc_inc;
   assign bus.pc_valid     = r_valid;
   assign bus.misalign_err = r_err;
   assign bus.bad_addr     = r_bad;
endmodule
